dds_phase_gen: RTL and testbench

Phase-accumulator front end for the sine-table DDS path: produces the 32-bit phase word DDS that the sine lookup consumes, one word per sample tick.
- Frequency tuning words (FTW) arrive over a valid/ready handshake and are applied either immediately or with exponential glide (portamento).
- GATE starts and stops the oscillator; SYNC hard-resets the phase.
- Sits between the note/control logic and the sine table.

---
 rtl/dds_pkg.sv | 14 +
 rtl/dds_tick_div.sv | 27 ++
 rtl/dds_phase_gen.sv | 153 +++++++++++++++
 tb/tb_dds_phase_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase path: default phase width, quadrant
// width and the phase-generator state encoding (also used by the sine table).
package dds_pkg;

  localparam int DEFAULT_PHASE_W = 32;
  localparam int QUAD_W          = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GLIDE = 2'd2
  } dds_state_t;

endpackage

// File: rtl/dds_tick_div.sv
// Sample-rate divider: strobes o_tick once every (i_div + 1) clock cycles.
module dds_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = (r_cnt == i_div);

  // Count up to the divide value and wrap; a divide value lowered below the
  // running count restarts the count without producing a tick.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (r_cnt >= i_div) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dds_phase_gen.sv
// Phase-accumulator front end for the sine-table DDS: accepts tuning words
// over valid/ready, optionally glides toward them, and emits one phase word
// per sample tick.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W     = DEFAULT_PHASE_W,
  parameter int DIV_W       = 16,
  parameter int GLIDE_SHIFT = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [DIV_W-1:0]   i_sample_div,
  input  logic [PHASE_W-1:0] i_ftw,
  input  logic               i_ftw_valid,
  output logic               o_ftw_ready,
  input  logic               i_glide_en,
  input  logic               i_gate,
  input  logic               i_sync,
  output logic [PHASE_W-1:0] o_dds,
  output logic               o_dds_valid,
  output logic [QUAD_W-1:0]  o_quadrant,
  output logic               o_wrap
);

  logic                      w_tick;
  logic                      w_xfer;
  logic [PHASE_W:0]          w_sum;
  logic signed [PHASE_W:0]   w_diff;
  logic signed [PHASE_W:0]   w_step;
  logic [PHASE_W-1:0]        w_glide_inc;

  logic [PHASE_W-1:0]        r_phase;
  logic [PHASE_W-1:0]        r_cur_inc;
  logic [PHASE_W-1:0]        r_target;
  logic                      r_full;
  logic                      r_ftw_ready;
  logic                      r_dds_valid;
  logic                      r_wrap;
  dds_state_t                r_state;

  dds_tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_div   (i_sample_div),
    .o_tick  (w_tick)
  );

  assign w_xfer      = i_ftw_valid && r_ftw_ready;
  assign o_ftw_ready = r_ftw_ready;
  assign o_dds       = r_phase;
  assign o_quadrant  = r_phase[PHASE_W-1 -: QUAD_W];
  assign o_dds_valid = r_dds_valid;
  assign o_wrap      = r_wrap;

  // Next-phase sum with carry, and the glide step: a signed fraction of the
  // remaining distance, never smaller than one LSB so the glide always lands.
  always_comb begin
    w_sum  = {1'b0, r_phase} + {1'b0, r_cur_inc};
    w_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_cur_inc});
    w_step = w_diff >>> GLIDE_SHIFT;
    if (!w_diff[PHASE_W] && (w_diff != '0) && (w_step == '0)) begin
      w_step = {{PHASE_W{1'b0}}, 1'b1};
    end
    w_glide_inc = r_cur_inc + w_step[PHASE_W-1:0];
  end

  // Handshake, oscillator FSM and registered phase outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_phase     <= '0;
      r_cur_inc   <= '0;
      r_target    <= '0;
      r_full      <= 1'b0;
      r_ftw_ready <= 1'b1;
      r_dds_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_state     <= ST_IDLE;
    end else begin
      r_dds_valid <= 1'b0;
      r_wrap      <= 1'b0;

      if (w_xfer) begin
        r_target    <= i_ftw;
        r_full      <= 1'b1;
        r_ftw_ready <= 1'b0;
      end

      if (w_tick) begin
        case (r_state)
          ST_IDLE: begin
            r_phase <= '0;
            if (r_full) begin
              r_cur_inc   <= r_target;
              r_full      <= 1'b0;
              r_ftw_ready <= 1'b1;
            end
            if (i_gate) begin
              r_state     <= ST_RUN;
              r_dds_valid <= 1'b1;
            end
          end

          ST_RUN, ST_GLIDE: begin
            if (!i_gate) begin
              r_state <= ST_IDLE;
              r_phase <= '0;
              if (r_full) begin
                r_cur_inc   <= r_target;
                r_full      <= 1'b0;
                r_ftw_ready <= 1'b1;
              end
            end else begin
              r_dds_valid <= 1'b1;
              if (i_sync) begin
                r_phase <= '0;
              end else begin
                r_phase <= w_sum[PHASE_W-1:0];
                r_wrap  <= w_sum[PHASE_W];
              end

              if (r_state == ST_RUN) begin
                if (r_full) begin
                  if (i_glide_en) begin
                    r_state <= ST_GLIDE;
                  end else begin
                    r_cur_inc   <= r_target;
                    r_full      <= 1'b0;
                    r_ftw_ready <= 1'b1;
                  end
                end
              end else begin
                r_cur_inc <= w_glide_inc;
                if (w_glide_inc == r_target) begin
                  r_full      <= 1'b0;
                  r_ftw_ready <= 1'b1;
                  r_state     <= ST_RUN;
                end
              end
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen: reset, divider spacing, quadrant/wrap,
// handshake hold-off, sync, glide trajectory, gate drop mid-glide and an
// asynchronous reset while running.
module tb_dds_phase_gen;

  localparam int PW = 32;
  localparam int DW = 16;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [DW-1:0] i_sample_div;
  logic [PW-1:0] i_ftw;
  logic          i_ftw_valid;
  logic          o_ftw_ready;
  logic          i_glide_en;
  logic          i_gate;
  logic          i_sync;
  logic [PW-1:0] o_dds;
  logic          o_dds_valid;
  logic [1:0]    o_quadrant;
  logic          o_wrap;

  int nVectors     = 0;
  int nMiscompares = 0;

  dds_phase_gen #(
    .PHASE_W     (PW),
    .DIV_W       (DW),
    .GLIDE_SHIFT (4)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_sample_div (i_sample_div),
    .i_ftw        (i_ftw),
    .i_ftw_valid  (i_ftw_valid),
    .o_ftw_ready  (o_ftw_ready),
    .i_glide_en   (i_glide_en),
    .i_gate       (i_gate),
    .i_sync       (i_sync),
    .o_dds        (o_dds),
    .o_dds_valid  (o_dds_valid),
    .o_quadrant   (o_quadrant),
    .o_wrap       (o_wrap)
  );

  // 10 ns system clock
  always #5 i_clk = ~i_clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [PW-1:0] observed,
                             input logic [PW-1:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Offer one tuning word; the block is expected to be ready
  task automatic applyStimulus(input logic [PW-1:0] ftw);
    i_ftw       = ftw;
    i_ftw_valid = 1'b1;
    step();
    i_ftw_valid = 1'b0;
    checkOutput("ready low after transfer", {31'd0, o_ftw_ready}, 32'd0);
  endtask

  // Wait (bounded) for the next emitted phase word
  task automatic waitValid(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!o_dds_valid && cycles < 40);
    checkOutput("dds_valid seen", {31'd0, o_dds_valid}, 32'd1);
  endtask

  // Wait (bounded) for FTW_READY to come back
  task automatic waitReady(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!o_ftw_ready && cycles < 40);
    checkOutput("ready reasserted", {31'd0, o_ftw_ready}, 32'd1);
  endtask

  initial begin
    logic [PW-1:0] expDds [5];
    logic [1:0]    expQuad [5];
    logic          expWrap [5];
    logic [PW-1:0] deltas [100];
    logic [PW-1:0] prev;
    logic [PW-1:0] model;
    logic [PW-1:0] stepVal;
    int            cyc;
    int            cnt;
    int            idx;
    int            errs;

    expDds  = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000};
    expQuad = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    expWrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    i_reset      = 1'b1;
    i_sample_div = 16'd3;
    i_ftw        = '0;
    i_ftw_valid  = 1'b0;
    i_glide_en   = 1'b0;
    i_gate       = 1'b0;
    i_sync       = 1'b0;

    // ---- reset state
    repeat (3) step();
    checkOutput("reset dds", o_dds, 32'd0);
    checkOutput("reset dds_valid", {31'd0, o_dds_valid}, 32'd0);
    checkOutput("reset wrap", {31'd0, o_wrap}, 32'd0);
    checkOutput("reset quadrant", {30'd0, o_quadrant}, 32'd0);
    checkOutput("reset ready", {31'd0, o_ftw_ready}, 32'd1);
    i_reset = 1'b0;

    // ---- quarter-turn increment, one tick per 4 clocks
    applyStimulus(32'h4000_0000);
    waitReady(cyc);
    i_gate = 1'b1;
    for (int k = 0; k < 5; k++) begin
      waitValid(cyc);
      checkOutput($sformatf("spacing %0d", k), cyc, 32'd4);
      checkOutput($sformatf("dds seq %0d", k), o_dds, expDds[k]);
      checkOutput($sformatf("quad seq %0d", k), {30'd0, o_quadrant}, {30'd0, expQuad[k]});
      checkOutput($sformatf("wrap seq %0d", k), {31'd0, o_wrap}, {31'd0, expWrap[k]});
    end

    // ---- sync: suppress the wrap at 0xC000_0000 -> 0
    waitValid(cyc);
    checkOutput("pre-sync 1", o_dds, 32'h4000_0000);
    waitValid(cyc);
    checkOutput("pre-sync 2", o_dds, 32'h8000_0000);
    waitValid(cyc);
    checkOutput("pre-sync 3", o_dds, 32'hC000_0000);
    i_sync = 1'b1;
    waitValid(cyc);
    checkOutput("sync dds", o_dds, 32'd0);
    checkOutput("sync wrap", {31'd0, o_wrap}, 32'd0);
    i_sync = 1'b0;
    waitValid(cyc);
    checkOutput("post-sync dds", o_dds, 32'h4000_0000);

    // ---- gate off: no more phase words
    i_gate = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (o_dds_valid) cnt++;
    end
    checkOutput("idle valid count", cnt, 32'd0);
    checkOutput("idle dds", o_dds, 32'd0);

    // ---- handshake hold-off with a slow divider
    i_sample_div = 16'd15;
    applyStimulus(32'h0300_0000);
    waitReady(cyc);
    i_ftw       = 32'h0800_0000;
    i_ftw_valid = 1'b1;
    step();
    checkOutput("ready low held 1", {31'd0, o_ftw_ready}, 32'd0);
    for (int k = 2; k <= 5; k++) begin
      i_ftw = 32'hDEAD_0000 + k;
      step();
    end
    checkOutput("ready low held 5", {31'd0, o_ftw_ready}, 32'd0);
    i_ftw_valid = 1'b0;
    waitReady(cyc);
    checkOutput("ready reassert delay", cyc, 32'd11);
    i_sample_div = 16'd0;
    i_gate = 1'b1;
    waitValid(cyc);
    checkOutput("restart latency", cyc, 32'd1);
    checkOutput("restart dds", o_dds, 32'd0);
    waitValid(cyc);
    checkOutput("held ftw 1", o_dds, 32'h0800_0000);
    waitValid(cyc);
    checkOutput("held ftw 2", o_dds, 32'h1000_0000);

    // ---- glide 0x100 -> 0x200
    applyStimulus(32'h0000_0100);
    waitReady(cyc);
    i_glide_en = 1'b1;
    applyStimulus(32'h0000_0200);
    prev = o_dds;
    for (int k = 0; k < 100; k++) begin
      step();
      deltas[k] = o_dds - prev;
      prev = o_dds;
    end
    idx = 0;
    while (idx < 99 && deltas[idx] == 32'h100) idx++;
    checkOutput("glide start index", idx, 32'd2);
    checkOutput("glide first step", deltas[idx], 32'h110);
    checkOutput("glide second step", deltas[idx+1], 32'h11F);
    model = 32'h100;
    errs  = 0;
    for (int j = idx; j < 100 && model != 32'h200; j++) begin
      stepVal = (32'h200 - model) >> 4;
      if (stepVal == 0) stepVal = 1;
      model = model + stepVal;
      if (deltas[j] !== model) errs++;
    end
    checkOutput("glide trajectory errors", errs, 32'd0);
    checkOutput("glide model landed", model, 32'h200);
    checkOutput("glide final inc", deltas[99], 32'h200);
    checkOutput("glide ready", {31'd0, o_ftw_ready}, 32'd1);

    // ---- gate drop mid-glide completes the glide
    applyStimulus(32'h0000_1000);
    repeat (4) step();
    i_gate = 1'b0;
    step();
    checkOutput("gate drop dds", o_dds, 32'd0);
    checkOutput("gate drop valid", {31'd0, o_dds_valid}, 32'd0);
    checkOutput("gate drop ready", {31'd0, o_ftw_ready}, 32'd1);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (o_dds_valid) cnt++;
    end
    checkOutput("gated valid count", cnt, 32'd0);
    i_gate = 1'b1;
    waitValid(cyc);
    checkOutput("regate first dds", o_dds, 32'd0);
    waitValid(cyc);
    checkOutput("regate second dds", o_dds, 32'h0000_1000);

    // ---- asynchronous reset while gliding
    applyStimulus(32'h0000_4000);
    repeat (2) step();
    #3;
    i_reset = 1'b1;
    #1;
    checkOutput("async reset dds", o_dds, 32'd0);
    checkOutput("async reset valid", {31'd0, o_dds_valid}, 32'd0);
    checkOutput("async reset wrap", {31'd0, o_wrap}, 32'd0);
    checkOutput("async reset quadrant", {30'd0, o_quadrant}, 32'd0);
    checkOutput("async reset ready", {31'd0, o_ftw_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
